// File: rtl/vanilla_interrupt_sequencer.sv
// Interrupt entry/exit sequencer: arms on a pending enabled interrupt, enters at a safe point,
// tracks handler residency and holds off re-entry after mret. Perf counters via INTR_SEQ_PERF_EN.
module vanilla_interrupt_sequencer #(
    parameter int unsigned                pc_width_p      = 22,
    parameter logic [pc_width_p-1:0]      remote_vector_p = pc_width_p'('h000010),
    parameter logic [pc_width_p-1:0]      trace_vector_p  = pc_width_p'('h000020),
    parameter int unsigned                holdoff_p       = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  mstatus_mie_i,
    input  logic [1:0]            mip_i,
    input  logic [1:0]            mie_i,
    input  logic                  safe_point_i,
    input  logic                  instr_executed_i,
    input  logic                  mret_i,
    output logic                  interrupt_entered_o,
    output logic                  redirect_v_o,
    output logic [pc_width_p-1:0] redirect_pc_o,
    output logic [1:0]            cause_o,
`ifdef INTR_SEQ_PERF_EN
    output logic [31:0]           remote_count_o,
    output logic [31:0]           trace_count_o,
    output logic [31:0]           arm_wait_cycles_o,
`endif
    output logic                  in_handler_o
);

    localparam int unsigned cnt_width_lp = (holdoff_p + 1 <= 1) ? 1 : $clog2(holdoff_p + 1);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StEnter,
        StHandler,
        StHoldoff
    } state_e;

    state_e                  state_q, state_d;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic [1:0]              cause_q, cause_d;

    logic pend;
    logic sel_remote;

    assign pend       = mstatus_mie_i & (|(mip_i & mie_i));
    assign sel_remote = mip_i[0] & mie_i[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        unique case (state_q)
            StIdle: begin
                if (pend) state_d = StArm;
            end
            StArm: begin
                if (!pend) begin
                    state_d = StIdle;
                end else if (safe_point_i) begin
                    state_d = StEnter;
                    cause_d = sel_remote ? 2'b01 : 2'b10;
                end
            end
            // Entry is committed once the strobe is issued; pend is not re-examined.
            StEnter: state_d = StHandler;
            StHandler: begin
                if (mret_i) begin
                    if (holdoff_p == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StHoldoff;
                        cnt_d   = cnt_width_lp'(holdoff_p);
                    end
                end
            end
            StHoldoff: begin
                if (instr_executed_i) begin
                    cnt_d = cnt_q - cnt_width_lp'(1);
                    if (cnt_q == cnt_width_lp'(1)) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        interrupt_entered_o = (state_q == StEnter);
        redirect_v_o        = (state_q == StEnter);
        in_handler_o        = (state_q == StHandler);
        cause_o             = cause_q;
        redirect_pc_o       = '0;
        if (state_q == StEnter) begin
            redirect_pc_o = cause_q[0] ? remote_vector_p : trace_vector_p;
        end
    end

`ifdef INTR_SEQ_PERF_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            remote_count_o    <= '0;
            trace_count_o     <= '0;
            arm_wait_cycles_o <= '0;
        end else begin
            if (state_q == StArm) arm_wait_cycles_o <= arm_wait_cycles_o + 32'd1;
            if (state_q == StEnter) begin
                if (cause_q[0]) remote_count_o <= remote_count_o + 32'd1;
                else            trace_count_o  <= trace_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/vanilla_interrupt_sequencer.md
Name: vanilla_interrupt_sequencer

Overview:
Sequences interrupt entry and exit for the vanilla core around the machine CSR block. It watches mstatus.MIE, MIP and MIE, waits for a pipeline safe point, then pulses the entry strobe and redirects fetch to the per-cause vector. It tracks handler residency until mret. After mret, it enforces an instruction-count holdoff so trace interrupts make forward progress.

Parameters:
pc_width_p, 22, width of the word-address PC and redirect target.
remote_vector_p, 22'h000010, word-address handler vector for remote interrupts.
trace_vector_p, 22'h000020, word-address handler vector for trace interrupts.
holdoff_p, 1, instructions that must execute after mret before the next entry; 0 disables holdoff.

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous, active-low reset
mstatus_mie_i  in  1  global interrupt enable, registered CSR value
mip_i  in  2  pending bits: [1]=trace, [0]=remote
mie_i  in  2  enable bits, same layout as mip_i
safe_point_i  in  1  pipeline can be flushed and redirected this cycle
instr_executed_i  in  1  one instruction moved ID->EXE this cycle
mret_i  in  1  mret is executing in EXE this cycle
interrupt_entered_o  out  1  one-cycle entry strobe to CSR block and pipeline flush
redirect_v_o  out  1  fetch redirect valid; asserted in the same cycle as interrupt_entered_o
redirect_pc_o  out  pc_width_p  redirect target vector
cause_o  out  2  one-hot cause of the current or last entry, same layout as mip_i
in_handler_o  out  1  core is executing a handler

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on reset_n_i.
- pend = mstatus_mie_i & |(mip_i & mie_i).
- Cause priority: remote > trace. sel = remote if (mip_i[0] & mie_i[0]), else trace.
- States and transitions:
  - IDLE: if pend -> ARM.
  - ARM: if !pend -> IDLE (request withdrawn by CSR write or remote clear). Else if safe_point_i -> ENTER, latching cause_r = sel in the same edge.
  - ENTER: lasts exactly 1 cycle. interrupt_entered_o=1, redirect_v_o=1, redirect_pc_o = vector of cause_r. Always -> HANDLER; a drop of pend here is ignored because entry is committed.
  - HANDLER: in_handler_o=1. On mret_i: if holdoff_p==0 -> IDLE; otherwise -> HOLDOFF with cnt=holdoff_p.
  - HOLDOFF: cnt decrements on each instr_executed_i. When cnt==1 and instr_executed_i -> IDLE. pend is not sampled in this state.
- Output timing: all outputs are decoded from registered state and cause_r only; there is no combinational input-to-output path.
- Minimum latency: pend seen in cycle t, safe_point_i in cycle t+1, interrupt_entered_o in cycle t+2.
- Holdoff counter width: `BSG_SAFE_CLOG2(holdoff_p+1)`; no wrap.
- Ignored events: mret_i in IDLE, ARM, ENTER or HOLDOFF is ignored. instr_executed_i outside HOLDOFF is ignored.
- Simultaneous events: mret_i and pend high together in HANDLER -> HOLDOFF (or IDLE when holdoff_p==0); a new entry needs a fresh ARM.
- Reset values: state=IDLE, cnt=0, cause_r=2'b00. All outputs read 0; redirect_pc_o=0.
- Reset mid-handler or mid-ENTER: immediate return to IDLE with outputs deasserted; no strobe completes.
- redirect_pc_o: equals the latched vector in ENTER and 0 in all other states.

Optional Feature:
Macro INTR_SEQ_PERF_EN.
- Defined: adds outputs remote_count_o[31:0], trace_count_o[31:0] and arm_wait_cycles_o[31:0].
  - remote_count_o / trace_count_o increment in each ENTER cycle for the latched cause.
  - arm_wait_cycles_o increments every cycle spent in ARM.
  - All three reset to 0 and wrap modulo 2^32.
- Not defined: these ports and registers do not exist; all other behaviour is unchanged.

Test Plan:
- mstatus_mie=1, mie=2'b01, mip=2'b01, safe_point_i=1 at reset release -> ARM next cycle; interrupt_entered_o high for exactly 1 cycle 2 cycles after pend; redirect_pc_o=22'h000010; cause_o=2'b01; in_handler_o=1 from the following cycle.
- mip=2'b11, mie=2'b11, safe_point_i held 0 for 5 cycles then 1 -> no strobe during the wait; entry after safe_point_i rises with cause_o=2'b01 (remote beats trace).
- In ARM, drop mstatus_mie_i before safe_point_i rises -> back to IDLE; no strobe; cause_o holds its prior value.
- holdoff_p=1, trace pending, mret_i in HANDLER -> no entry until one instr_executed_i pulse; after that pulse, re-entry to ARM, then ENTER with redirect_pc_o=22'h000020.
- Drop reset_n_i asynchronously during HANDLER -> in_handler_o=0 immediately; after release the state is IDLE and a new pend produces a normal entry.
- With INTR_SEQ_PERF_EN: 3 remote and 2 trace entries with a 4-cycle ARM wait on one of them -> remote_count_o=3, trace_count_o=2, arm_wait_cycles_o equal to the total ARM cycles.
